// File: rtl/chip_master_seq.sv
// chip_master_seq: host-side sequencer for the Master end of chip_ports.
// Accepts one command at a time, plays it out as setup / strobe / hold pin
// timing toward the chip, samples bit_out where needed and returns a response.
module chip_master_seq #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned INFER_CYC = 16,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_col,
  input  logic [7:0] cmd_row,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       chip_clk,
  output logic       CBL,
  output logic       CBLEN,
  output logic       CWL,
  output logic       inference,
  output logic       load_seed,
  output logic       read_1,
  output logic       read_8,
  output logic       load_mem,
  output logic       read_out,
  output logic       stoch_log,
  output logic [7:0] addr_full_col,
  output logic [7:0] addr_full_row,
  output logic [7:0] seeds,
  input  logic [3:0] bit_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_WRITE   = 3'd0,
    OP_READ1   = 3'd1,
    OP_READ8   = 3'd2,
    OP_SEED    = 3'd3,
    OP_INFER   = 3'd4,
    OP_LOADMEM = 3'd5
  } op_e;

  state_e     state;
  op_e        op_q;
  logic [7:0] cnt;
  logic       pass_q;

  // Address, mode and data pins are loaded straight from the command on
  // acceptance and hold their value until RESP, so they double as the
  // latched col/row/data copy of the command.
  // Sequencer FSM; every pin and response output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= OP_WRITE;
      cnt           <= '0;
      pass_q        <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      chip_clk      <= 1'b0;
      CBL           <= 1'b0;
      CBLEN         <= 1'b0;
      CWL           <= 1'b0;
      inference     <= 1'b0;
      load_seed     <= 1'b0;
      read_1        <= 1'b0;
      read_8        <= 1'b0;
      load_mem      <= 1'b0;
      read_out      <= 1'b0;
      stoch_log     <= 1'b0;
      addr_full_col <= '0;
      addr_full_row <= '0;
      seeds         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= op_e'(cmd_op);
            rsp_data  <= '0;
            if (cmd_op > 3'd5) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state         <= ST_SETUP;
              cnt           <= 8'(SETUP_CYC - 1);
              pass_q        <= 1'b0;
              addr_full_col <= cmd_col;
              addr_full_row <= cmd_row;
              CBLEN         <= (cmd_op == OP_WRITE);
              CBL           <= (cmd_op == OP_WRITE) && cmd_data[0];
              seeds         <= (cmd_op == OP_SEED) ? cmd_data : '0;
              stoch_log     <= (cmd_op == OP_INFER) && cmd_data[0];
              read_out      <= 1'b0;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'd0) begin
            state     <= ST_PULSE;
            cnt       <= (op_q == OP_INFER) ? 8'(INFER_CYC - 1) : 8'(PULSE_CYC - 1);
            chip_clk  <= 1'b1;
            CWL       <= (op_q == OP_WRITE);
            read_1    <= (op_q == OP_READ1);
            read_8    <= (op_q == OP_READ8);
            load_seed <= (op_q == OP_SEED);
            inference <= (op_q == OP_INFER);
            load_mem  <= (op_q == OP_LOADMEM);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_PULSE: begin
          chip_clk <= 1'b0;
          if (cnt == 8'd0) begin
            state     <= ST_HOLD;
            cnt       <= 8'(HOLD_CYC - 1);
            CWL       <= 1'b0;
            read_1    <= 1'b0;
            read_8    <= 1'b0;
            load_seed <= 1'b0;
            inference <= 1'b0;
            load_mem  <= 1'b0;
            case (op_q)
              OP_READ1: rsp_data <= {7'd0, bit_out[0]};
              OP_READ8: begin
                if (pass_q) rsp_data[7:4] <= bit_out;
                else        rsp_data[3:0] <= bit_out;
              end
              OP_INFER: rsp_data <= {4'd0, bit_out};
              default:  ;
            endcase
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) begin
            if (op_q == OP_READ8 && !pass_q) begin
              pass_q   <= 1'b1;
              read_out <= 1'b1;
              state    <= ST_SETUP;
              cnt      <= 8'(SETUP_CYC - 1);
            end else begin
              state         <= ST_RESP;
              rsp_valid     <= 1'b1;
              addr_full_col <= '0;
              addr_full_row <= '0;
              seeds         <= '0;
              CBL           <= 1'b0;
              CBLEN         <= 1'b0;
              stoch_log     <= 1'b0;
              read_out      <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_master_seq.sv
// Testbench for chip_master_seq: directed vector table, hand-written reset
// sequences and randomized commands checked against a timeline model.
module tb_chip_master_seq;

  localparam int S  = 2;
  localparam int PC = 4;
  localparam int IC = 16;
  localparam int H  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_col, cmd_row, cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       chip_clk, CBL, CBLEN, CWL, inference, load_seed, read_1, read_8;
  logic       load_mem, read_out, stoch_log;
  logic [7:0] addr_full_col, addr_full_row, seeds;
  logic [3:0] bit_out;
  logic [3:0] nib_lo, nib_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Chip stub: result nibble depends on which READ8 pass is active.
  assign bit_out = read_out ? nib_hi : nib_lo;

  chip_master_seq #(.SETUP_CYC(S), .PULSE_CYC(PC), .INFER_CYC(IC), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .chip_clk(chip_clk), .CBL(CBL), .CBLEN(CBLEN), .CWL(CWL), .inference(inference),
    .load_seed(load_seed), .read_1(read_1), .read_8(read_8), .load_mem(load_mem),
    .read_out(read_out), .stoch_log(stoch_log),
    .addr_full_col(addr_full_col), .addr_full_row(addr_full_row), .seeds(seeds),
    .bit_out(bit_out)
  );

  logic [34:0] act_pins;
  assign act_pins = {chip_clk, CBL, CBLEN, CWL, inference, load_seed, read_1, read_8,
                     load_mem, read_out, stoch_log, addr_full_col, addr_full_row, seeds};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pulse_len(input int op);
    return (op == 4) ? IC : PC;
  endfunction

  function automatic int lat(input int op);
    if (op > 5) return 1;
    if (op == 2) return 2 * (S + PC + H) + 1;
    return S + pulse_len(op) + H + 1;
  endfunction

  function automatic logic [7:0] ref_rsp(input int op, input logic [3:0] lo, input logic [3:0] hi);
    case (op)
      1:       return {7'd0, lo[0]};
      2:       return {hi, lo};
      4:       return {4'd0, lo};
      default: return 8'h00;
    endcase
  endfunction

  // Expected pin vector c cycles after acceptance, from the phase timeline.
  function automatic logic [34:0] exp_pins(input int op, input logic [7:0] col, input logic [7:0] row,
                                           input logic [7:0] data, input int c);
    logic [34:0] e;
    int pl, plen, pass, t;
    e = '0;
    if (op > 5 || c >= lat(op)) return e;
    pl   = pulse_len(op);
    plen = S + pl + H;
    pass = (c - 1) / plen;
    t    = (c - 1) % plen + 1;
    e[23:16] = col;
    e[15:8]  = row;
    e[7:0]   = (op == 3) ? data : 8'h00;
    e[24]    = (op == 4) && data[0];
    e[25]    = (op == 2) && (pass == 1);
    e[32]    = (op == 0);
    e[33]    = (op == 0) && data[0];
    if (t > S && t <= S + pl) begin
      case (op)
        0: e[31] = 1'b1;
        4: e[30] = 1'b1;
        3: e[29] = 1'b1;
        1: e[28] = 1'b1;
        2: e[27] = 1'b1;
        5: e[26] = 1'b1;
        default: ;
      endcase
      e[34] = (t == S + 1);
    end
    return e;
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] col, input logic [7:0] row,
                         input logic [7:0] data, input logic [3:0] lo, input logic [3:0] hi,
                         input logic [7:0] exp_data, input logic exp_err, input int exp_lat,
                         input int dly);
    int w;
    nib_lo = lo;
    nib_hi = hi;
    cmd_op = op; cmd_col = col; cmd_row = row; cmd_data = data;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    cmd_op = 3'(op + 3'd1); cmd_col = 8'($urandom); cmd_row = 8'($urandom); cmd_data = 8'($urandom);
    for (int c = 1; c <= exp_lat; c++) begin
      if (c < exp_lat) begin
        chk($sformatf("pins op%0d c%0d", op, c), 64'({rsp_valid, act_pins}),
            64'({1'b0, exp_pins(int'(op), col, row, data, c)}));
        step();
      end else begin
        chk($sformatf("rsp op%0d c%0d", op, c),
            64'({rsp_valid, rsp_err, rsp_data, cmd_ready, act_pins}),
            64'({1'b1, exp_err, exp_data, 1'b0, 35'd0}));
      end
    end
    for (int k = 0; k < dly; k++) begin
      step();
      chk($sformatf("stall op%0d k%0d", op, k), 64'({rsp_valid, rsp_err, rsp_data, cmd_ready}),
          64'({1'b1, exp_err, exp_data, 1'b0}));
    end
    // Offer a command in the handshake cycle; it must not be taken.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk($sformatf("handshake op%0d", op), 64'({rsp_valid, cmd_ready, rsp_err}), 64'({1'b0, 1'b1, 1'b0}));
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] col, row, data;
    logic [3:0] lo, hi;
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         dly;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{op:3'd0, col:8'h12, row:8'h34, data:8'h01, lo:4'h0, hi:4'h0, rdata:8'h00, err:1'b0, lat:9,  dly:0};
    tbl[1] = '{op:3'd2, col:8'h05, row:8'h06, data:8'h00, lo:4'hA, hi:4'h5, rdata:8'h5A, err:1'b0, lat:17, dly:1};
    tbl[2] = '{op:3'd4, col:8'h77, row:8'h01, data:8'h01, lo:4'h7, hi:4'h0, rdata:8'h07, err:1'b0, lat:21, dly:0};
    tbl[3] = '{op:3'd6, col:8'hFF, row:8'hFF, data:8'hFF, lo:4'hF, hi:4'hF, rdata:8'h00, err:1'b1, lat:1,  dly:5};
    tbl[4] = '{op:3'd1, col:8'h00, row:8'hFF, data:8'h00, lo:4'h3, hi:4'h0, rdata:8'h01, err:1'b0, lat:9,  dly:2};
    tbl[5] = '{op:3'd1, col:8'h80, row:8'h01, data:8'h00, lo:4'hE, hi:4'h1, rdata:8'h00, err:1'b0, lat:9,  dly:0};
    tbl[6] = '{op:3'd3, col:8'h10, row:8'h20, data:8'hC3, lo:4'h9, hi:4'h0, rdata:8'h00, err:1'b0, lat:9,  dly:0};
    tbl[7] = '{op:3'd5, col:8'hAA, row:8'h55, data:8'h00, lo:4'hF, hi:4'hF, rdata:8'h00, err:1'b0, lat:9,  dly:0};
    tbl[8] = '{op:3'd7, col:8'h01, row:8'h02, data:8'h03, lo:4'h0, hi:4'h0, rdata:8'h00, err:1'b1, lat:1,  dly:0};

    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_col = 8'h12; cmd_row = 8'h34; cmd_data = 8'h01;
    rsp_ready = 1'b0; nib_lo = 4'h0; nib_hi = 4'h0;
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset_pins", 64'(act_pins), 64'd0);
    chk("reset_rsp", 64'({cmd_ready, rsp_valid, rsp_err, rsp_data}), 64'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", 64'({cmd_ready, rsp_valid}), 64'({1'b1, 1'b0}));
    cmd_valid = 1'b0;
    step();
    chk("idle_quiet", 64'({cmd_ready, act_pins}), 64'({1'b1, 35'd0}));

    for (int i = 0; i < 9; i++)
      run_cmd(tbl[i].op, tbl[i].col, tbl[i].row, tbl[i].data, tbl[i].lo, tbl[i].hi,
              tbl[i].rdata, tbl[i].err, tbl[i].lat, tbl[i].dly);

    // Reset in the middle of a SEED strobe.
    begin
      int w;
      cmd_op = 3'd3; cmd_col = 8'h44; cmd_row = 8'h55; cmd_data = 8'hC3;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin step(); w++; end
      step();
      cmd_valid = 1'b0;
      w = 0;
      while (!load_seed && w < 20) begin step(); w++; end
      chk("seed_strobe_seen", 64'({load_seed, seeds}), 64'({1'b1, 8'hC3}));
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_pins", 64'(act_pins), 64'd0);
      chk("async_reset_rsp", 64'({rsp_valid, cmd_ready}), 64'd0);
      step();
      rst_n = 1'b1;
      w = 0;
      for (int k = 0; k < 25; k++) begin
        step();
        if (rsp_valid || act_pins != '0) w++;
      end
      chk("no_rsp_after_reset", 64'(w), 64'd0);
      chk("ready_after_abort", 64'(cmd_ready), 64'd1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] col, row, data;
      logic [3:0] lo, hi;
      op   = 3'($urandom_range(0, 7));
      col  = 8'($urandom); row = 8'($urandom); data = 8'($urandom);
      lo   = 4'($urandom_range(0, 15));
      hi   = 4'($urandom_range(0, 15));
      run_cmd(op, col, row, data, lo, hi, ref_rsp(int'(op), lo, hi), op > 3'd5, lat(int'(op)),
              $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_master_seq.md
Name: chip_master_seq

Overview:
- Host-side sequencer that drives the Master end of the chip_ports interface toward the stochastic memory/inference chip.
- Accepts one command at a time over a valid/ready port and expands it into timed pin sequences: address/data setup, strobe pulse, hold.
- Samples bit_out on reads and inference, then returns a result over a valid/ready response port.

Parameters:
- SETUP_CYC, 2, cycles address/data/mode lines are stable before the strobe (1..255)
- PULSE_CYC, 4, strobe-high cycles for write, read, seed and load_mem operations (1..255)
- INFER_CYC, 16, strobe-high cycles for an inference operation (1..255)
- HOLD_CYC, 2, cycles address/data are held after the strobe falls (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  3  0 WRITE, 1 READ1, 2 READ8, 3 SEED, 4 INFER, 5 LOADMEM, 6/7 illegal
- cmd_col  in  8  column address
- cmd_row  in  8  row address
- cmd_data  in  8  WRITE: bit0 = cell value; SEED: seed byte; INFER: bit0 = stoch_log
- rsp_valid  out  1  response available; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_data  out  8  read or inference result, zero-extended
- rsp_err  out  1  illegal opcode
- chip_clk  out  1  chip clock pin (chip_ports clk)
- CBL, CBLEN, CWL, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log  out  1 each  chip_ports Master control pins
- addr_full_col, addr_full_row, seeds  out  8 each  chip_ports Master buses
- bit_out  in  4  chip_ports result nibble

Behaviour:
- Reset (asynchronous, immediate): every output is 0, FSM returns to IDLE, counters clear, latched command discarded. A reset mid-operation drops all strobes in the same instant; no response is issued.
- cmd_ready is 1 only when FSM = IDLE and rsp_valid = 0.
- On acceptance, op/col/row/data are latched; later changes on cmd_* are ignored.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> (READ8 first pass: SETUP again with read_out = 1) -> RESP -> IDLE.
- Each state lasts exactly its parameter count in cycles. PULSE uses INFER_CYC for INFER and PULSE_CYC otherwise. Counters are 8-bit down-counters.
- SETUP: addr_full_col/row = latched col/row.
  - Mode/data lines are driven: CBLEN = 1 and CBL = data[0] for WRITE; seeds = data for SEED; stoch_log = data[0] for INFER; read_out = 0 on the first READ8 pass and 1 on the second.
- PULSE: the strobe for the op is high for the whole state.
  - Strobe per op: WRITE → CWL; READ1 → read_1; READ8 → read_8; SEED → load_seed; INFER → inference; LOADMEM → load_mem.
  - chip_clk is high only in the first PULSE cycle of each pass.
- Sampling: bit_out is captured at the clock edge ending the last PULSE cycle.
  - READ1 → rsp_data[0] = bit_out[0].
  - READ8 → pass 1 gives rsp_data[3:0], pass 2 gives rsp_data[7:4].
  - INFER → rsp_data[3:0] = bit_out.
  - WRITE, SEED and LOADMEM → rsp_data = 0.
- HOLD: strobe and chip_clk are low; address, data and mode lines are unchanged. All of them return to 0 on entering RESP.
- RESP: rsp_valid = 1 with data/err stable until rsp_ready. Handshake is at the edge where rsp_valid && rsp_ready; the FSM reaches IDLE the next cycle, and cmd_ready = 1 in that cycle.
- Latency from the acceptance edge to rsp_valid high:
  - single-pass ops: SETUP_CYC + pulse + HOLD_CYC + 1 cycles (defaults: 9; INFER 21);
  - READ8: 2*(SETUP_CYC + PULSE_CYC + HOLD_CYC) + 1 cycles (17).
- Illegal opcode: no pin activity. rsp_valid is high the cycle after acceptance with rsp_err = 1 and rsp_data = 0.
- Simultaneous rsp handshake and cmd_valid: the command is not accepted in that cycle, because cmd_ready is 0.
- At most one strobe is high at any time.

Test Plan:
- Reset with cmd_valid = 1 → all outputs 0; cmd_ready = 1 after rst_n rises.
- WRITE col=0x12 row=0x34 data=0x01 → CBLEN = 1 and CBL = 1 from cycle 1; CWL high in cycles 3–6; chip_clk high in cycle 3 only; rsp_valid in cycle 9 with rsp_data = 0.
- READ8 with bit_out = 0xA while read_out = 0 and 0x5 while read_out = 1 → rsp_data = 0x5A in cycle 17; read_8 pulses twice.
- INFER data=0x01 with bit_out = 0x7 → stoch_log = 1; inference high for 16 cycles; rsp_data = 0x07 in cycle 21.
- Op 6 → rsp_err = 1 in cycle 1; all chip pins stay 0. Hold rsp_ready = 0 for 5 cycles → rsp_valid and cmd_ready = 0 remain stable.
- Assert rst_n low during the PULSE of SEED (seeds = 0xC3) → load_seed and seeds drop to 0 immediately; no response after release.
